// File: rtl/echo_timer.sv
// echo_timer: synchronous echo-pulse width timer with prescaler,
// saturation/overflow reporting and a valid/ack result handshake.
module echo_timer #(
    parameter int WIDTH    = 9,
    parameter int PRESCALE = 58
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             echo,
    input  logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             overflow
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CMAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [PW-1:0] pre;
    logic          sync1, echo_s, echo_d;
    logic          rise, fall;
    logic          run;

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;
    assign busy = (state == ARMED) || (state == COUNT);

    // The edge that enters COUNT also counts, so a pulse of N cycles
    // sees exactly N prescaler steps before the fall is captured.
    assign run = ((state == COUNT) && !fall) || ((state == ARMED) && rise);

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync1  <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            sync1  <= echo;
            echo_s <= sync1;
            echo_d <= echo_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (start) state_nx = ARMED;
            ARMED: if (rise)  state_nx = COUNT;
            COUNT: if (fall)  state_nx = DONE;
            DONE:  if (ack)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Prescaler, saturating counter, result capture and handshake.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pre      <= '0;
            count    <= '0;
            result   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                pre      <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end
            if (run) begin
                if (pre == PMAX) begin
                    pre <= '0;
                    if (count == CMAX) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    pre <= pre + PW'(1);
                end
            end
            if ((state == COUNT) && fall) begin
                result <= count;
                valid  <= 1'b1;
            end
            if ((state == DONE) && ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_echo_timer.sv
// Bench for echo_timer: two instances (WIDTH=9/PRESCALE=4 and
// WIDTH=4/PRESCALE=1) share stimulus and are checked independently.
module tb_echo_timer;

    logic clk = 1'b0;
    logic clear, start, echo, ack;

    logic       busy_a, valid_a, ov_a;
    logic [8:0] count_a, result_a;
    logic       busy_b, valid_b, ov_b;
    logic [3:0] count_b, result_b;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    echo_timer #(.WIDTH(9), .PRESCALE(4)) dut_a (
        .clk(clk), .clear(clear), .start(start), .echo(echo), .ack(ack),
        .busy(busy_a), .count(count_a), .result(result_a),
        .valid(valid_a), .overflow(ov_a)
    );

    echo_timer #(.WIDTH(4), .PRESCALE(1)) dut_b (
        .clk(clk), .clear(clear), .start(start), .echo(echo), .ack(ack),
        .busy(busy_b), .count(count_b), .result(result_b),
        .valid(valid_b), .overflow(ov_b)
    );

    typedef struct {
        int n;
        bit pre;
        int ra;
        bit oa;
        int rb;
        bit ob;
    } vec_t;

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: result is the number of whole prescaled ticks in the
    // pulse, clipped to the largest WIDTH-bit value.
    function automatic int mres(int n, int p, int w);
        int q = n / p;
        int m = (1 << w) - 1;
        return (q > m) ? m : q;
    endfunction

    function automatic bit movf(int n, int p, int w);
        return (n / p) > ((1 << w) - 1);
    endfunction

    task automatic pulse(input int n, input bit pre, input int ackdly,
                         output int ra, output bit oa,
                         output int rb, output bit ob);
        if (pre) begin
            echo = 1'b1;
            repeat (5) @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start_a", busy_a, 1);
        chk("busy_after_start_b", busy_b, 1);
        if (pre) begin
            repeat (5) @(negedge clk);
            echo = 1'b0;
            repeat (5) @(negedge clk);
            chk("prehigh_not_counted", count_a, 0);
        end
        echo = 1'b1;
        repeat (n) @(negedge clk);
        echo = 1'b0;
        repeat (2) @(negedge clk);
        chk("valid_early_a", valid_a, 0);
        @(negedge clk);
        chk("valid_3edges_a", valid_a, 1);
        chk("valid_3edges_b", valid_b, 1);
        chk("busy_done_a", busy_a, 0);
        chk("count_eq_result_a", count_a, result_a);
        ra = result_a;
        oa = ov_a;
        rb = result_b;
        ob = ov_b;
        repeat (ackdly) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("valid_clr_a", valid_a, 0);
        chk("result_kept_a", result_a, ra);
        repeat (3) @(negedge clk);
    endtask

    vec_t tbl[9];

    initial begin
        int ra, rb;
        bit oa, ob;

        tbl[0] = '{40,   0, 10,  0, 15, 1};
        tbl[1] = '{7,    0, 1,   0, 7,  0};
        tbl[2] = '{20,   1, 5,   0, 15, 1};
        tbl[3] = '{12,   0, 3,   0, 12, 0};
        tbl[4] = '{16,   0, 4,   0, 15, 1};
        tbl[5] = '{2400, 0, 511, 1, 15, 1};
        tbl[6] = '{3,    0, 0,   0, 3,  0};
        tbl[7] = '{2,    0, 0,   0, 2,  0};
        tbl[8] = '{14,   0, 3,   0, 14, 0};

        clear = 1'b0;
        start = 1'b0;
        echo  = 1'b0;
        ack   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_result", result_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_ovf", ov_a, 0);
        clear = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            pulse(tbl[i].n, tbl[i].pre, i % 3, ra, oa, rb, ob);
            chk($sformatf("tbl%0d_res_a", i), ra, tbl[i].ra);
            chk($sformatf("tbl%0d_ovf_a", i), oa, tbl[i].oa);
            chk($sformatf("tbl%0d_res_b", i), rb, tbl[i].rb);
            chk($sformatf("tbl%0d_ovf_b", i), ob, tbl[i].ob);
        end

        // Handshake: result stable while ack is withheld; start ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        echo = 1'b1;
        repeat (24) @(negedge clk);
        echo = 1'b0;
        repeat (3) @(negedge clk);
        chk("hs_valid", valid_a, 1);
        chk("hs_res", result_a, 6);
        for (int c = 0; c < 50; c++) begin
            start = (c % 7 == 0);
            @(negedge clk);
            if (c % 10 == 9) begin
                chk("hs_hold_valid", valid_a, 1);
                chk("hs_hold_res", result_a, 6);
                chk("hs_hold_busy", busy_a, 0);
            end
        end
        ack = 1'b1;
        start = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        start = 1'b0;
        chk("hs_ack_valid", valid_a, 0);
        chk("hs_no_rearm", busy_a, 0);
        repeat (5) @(negedge clk);
        chk("hs_still_idle", busy_a, 0);
        chk("hs_res_kept", result_a, 6);

        // Clear mid-count.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        echo = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_counting", count_a > 0, 1);
        #2 clear = 1'b0;
        #1;
        chk("clr_count", count_a, 0);
        chk("clr_valid", valid_a, 0);
        chk("clr_busy", busy_a, 0);
        chk("clr_ovf", ov_a, 0);
        chk("clr_result", result_a, 0);
        @(negedge clk);
        clear = 1'b1;
        echo = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_no_partial", valid_a, 0);
        pulse(12, 0, 1, ra, oa, rb, ob);
        chk("after_clr_res_a", ra, 3);
        chk("after_clr_res_b", rb, 12);

        // Randomised pulses against the arithmetic reference.
        for (int r = 0; r < 25; r++) begin
            int n;
            n = int'($urandom_range(2, 150));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pulse(n, bit'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                  ra, oa, rb, ob);
            chk($sformatf("rnd%0d_n%0d_res_a", r, n), ra, mres(n, 4, 9));
            chk($sformatf("rnd%0d_n%0d_ovf_a", r, n), oa, movf(n, 4, 9));
            chk($sformatf("rnd%0d_n%0d_res_b", r, n), rb, mres(n, 1, 4));
            chk($sformatf("rnd%0d_n%0d_ovf_b", r, n), ob, movf(n, 1, 4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
